// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and helpers for the 2x2 stride-2 pooling engine
package pool_pkg;

    typedef enum logic {
        AVG = 1'b0,
        MAX = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pool_state_e;

    // Counter width that never collapses to zero bits for tiny maps.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_reduce4.sv
// rtl/pool_reduce4.sv - combinational 2x2 window reducer (floor average or signed max) for one lane
module pool_reduce4
    import pool_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] y
);

    logic signed [DATA_W+1:0] sum;
    logic signed [DATA_W+1:0] shifted;
    logic signed [DATA_W-1:0] max_ab;
    logic signed [DATA_W-1:0] max_cd;
    logic signed [DATA_W-1:0] max_all;

    always_comb begin
        // Two guard bits hold the 4-way sum; the arithmetic shift floors toward -inf.
        sum = {{2{a[DATA_W-1]}}, a} + {{2{b[DATA_W-1]}}, b}
            + {{2{c[DATA_W-1]}}, c} + {{2{d[DATA_W-1]}}, d};
        shifted = sum >>> 2;
        max_ab  = ($signed(a) > $signed(b)) ? a : b;
        max_cd  = ($signed(c) > $signed(d)) ? c : d;
        max_all = (max_ab > max_cd) ? max_ab : max_cd;
        y = (mode == MAX) ? max_all : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - streaming 2x2 stride-2 max/avg pooling over a raster feature map with one line buffer
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FM_W   = 6,
    parameter int FM_H   = 6,
    parameter int CH     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 busy,
    output logic                 done
);

    localparam int PX_W  = CH * DATA_W;
    localparam int COL_W = clog2_min1(FM_W);
    localparam int ROW_W = clog2_min1(FM_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FM_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FM_H - 1);

    generate
        if ((FM_W % 2) != 0) begin : g_bad_fm_w
            $error("pool2d_stream: FM_W must be even");
        end
        if ((FM_H % 2) != 0) begin : g_bad_fm_h
            $error("pool2d_stream: FM_H must be even");
        end
    endgenerate

    pool_state_e      state_q, state_d;
    pool_mode_e       mode_q, mode_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             out_valid_q, out_valid_d;
    logic [PX_W-1:0]  out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [PX_W-1:0]  line_buf_q [FM_W];
    logic [PX_W-1:0]  line_buf_d [FM_W];
    logic [PX_W-1:0]  prev_px_q, prev_px_d;

    logic             in_hs;
    logic             out_hs;
    logic             last_px;
    logic             load;
    logic [COL_W-1:0] col_m1;
    logic [PX_W-1:0]  pooled;

    assign in_ready = (state_q == RUN) && !(out_valid_q && !out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign load     = in_hs && row_q[0] && col_q[0];
    assign col_m1   = col_q - 1'b1;

    // Window: upper-left and upper-right from the line buffer, lower-left held, lower-right live.
    generate
        for (genvar k = 0; k < CH; k++) begin : g_lane
            pool_reduce4 #(.DATA_W(DATA_W)) u_reduce (
                .mode (mode_q == MAX),
                .a    (line_buf_q[col_m1][k*DATA_W +: DATA_W]),
                .b    (line_buf_q[col_q][k*DATA_W +: DATA_W]),
                .c    (prev_px_q[k*DATA_W +: DATA_W]),
                .d    (in_data[k*DATA_W +: DATA_W]),
                .y    (pooled[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        line_buf_d  = line_buf_q;
        prev_px_d   = prev_px_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = pool_mode_e'(mode);
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN:     if (in_hs && last_px) state_d = DRAIN;
            DRAIN:   if (!out_valid_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (in_hs) begin
            if (!row_q[0]) begin
                line_buf_d[col_q] = in_data;
            end else if (!col_q[0]) begin
                prev_px_d = in_data;
            end
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = pooled;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= AVG;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Pixel storage is never read before the current frame rewrites it, so it skips reset.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
        prev_px_q  <= prev_px_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pool2d_stream.sv
// tb/tb_pool2d_stream.sv - scoreboard bench for pool2d_stream (4x4 two-lane and default 6x6 instances)
module tb_pool2d_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic        a_start, a_mode, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
    logic [63:0] a_in_data, a_out_data;
    logic        b_start, b_mode, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
    logic [31:0] b_in_data, b_out_data;

    pool2d_stream #(.DATA_W(32), .FM_W(4), .FM_H(4), .CH(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy), .done(a_done)
    );

    pool2d_stream dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy), .done(b_done)
    );

    logic [63:0] q_a[$];
    logic [31:0] q_b[$];
    int          a_nout = 0, b_nout = 0, a_ndone = 0, b_ndone = 0, a_done_cyc = 0;
    logic [63:0] pix_a [16];
    logic [63:0] exp_a [4];
    logic [31:0] pix_b [36];
    bit          b_rand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk2(input int l0, input int l1);
        return {l1, l0};
    endfunction

    function automatic logic [31:0] ref_pool(input bit m, input int p0, input int p1, input int p2, input int p3);
        longint s;
        int     mx;
        if (m) begin
            mx = p0;
            if (p1 > mx) mx = p1;
            if (p2 > mx) mx = p2;
            if (p3 > mx) mx = p3;
            return mx;
        end
        s = longint'(p0) + longint'(p1) + longint'(p2) + longint'(p3);
        s = s >>> 2;
        return s[31:0];
    endfunction

    // Output monitors: pop the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            a_nout++;
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_output: got %0h, expected no output", a_out_data);
            end else begin
                chk("a_out_data", a_out_data, q_a.pop_front());
            end
        end
        if (a_done) begin
            a_ndone++;
            a_done_cyc = cyc;
        end
        if (b_out_valid && b_out_ready) begin
            b_nout++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_output: got %0h, expected no output", b_out_data);
            end else begin
                chk("b_out_data", 64'(b_out_data), 64'(q_b.pop_front()));
            end
        end
        if (b_out_valid && !b_out_ready) chk("b_in_ready_when_stalled", 64'(b_in_ready), 64'(0));
        if (b_done) b_ndone++;
    end

    initial begin
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b_out_ready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_a(input logic [63:0] d);
        bit acc = 1'b0;
        int guard = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        a_in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL a_send_timeout: got in_ready=0, expected 1 within 100 cycles");
        end
    endtask

    task automatic send_b(input logic [31:0] d);
        bit acc = 1'b0;
        int guard = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = b_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        b_in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL b_send_timeout: got in_ready=0, expected 1 within 200 cycles");
        end
    endtask

    task automatic frame_a(input bit m, input int glitch, input int n_px, input bit want_lat);
        int k = 0;
        int d0 = a_ndone;
        int st;
        int g = 0;
        a_mode  = m;
        a_start = 1'b1;
        st      = cyc;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        a_mode  = ~m;
        chk("a_busy_after_start", 64'(a_busy), 64'(1));
        chk("a_in_ready_after_start", 64'(a_in_ready), 64'(1));
        for (int i = 0; i < n_px; i++) begin
            if (i == glitch) a_start = 1'b1;
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
                q_a.push_back(exp_a[k]);
                k++;
            end
            send_a(pix_a[i]);
            a_start = 1'b0;
        end
        if (n_px == 16) begin
            while (a_ndone == d0 && g < 200) begin
                @(posedge clk);
                #1;
                g++;
            end
            if (want_lat) chk("a_done_latency", 64'(a_done_cyc - st), 64'(19));
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            chk("a_done_once", 64'(a_ndone - d0), 64'(1));
            chk("a_no_missing_output", 64'(q_a.size()), 64'(0));
        end
    endtask

    task automatic frame_b(input bit m);
        int d0 = b_ndone;
        int n0 = b_nout;
        int g = 0;
        for (int i = 0; i < 36; i++) pix_b[i] = $urandom;
        b_mode  = m;
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        b_mode  = ~m;
        chk("b_busy_after_start", 64'(b_busy), 64'(1));
        for (int i = 0; i < 36; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (((i / 6) % 2 == 1) && ((i % 6) % 2 == 1))
                q_b.push_back(ref_pool(m, pix_b[i-7], pix_b[i-6], pix_b[i-1], pix_b[i]));
            send_b(pix_b[i]);
        end
        while (b_ndone == d0 && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("b_done_once", 64'(b_ndone - d0), 64'(1));
        chk("b_output_count", 64'(b_nout - n0), 64'(9));
        chk("b_no_missing_output", 64'(q_b.size()), 64'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test, expected finish before 3 ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_mode = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_start = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("rst_a_in_ready", 64'(a_in_ready), 64'(0));
        chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_a_out_data", a_out_data, 64'(0));
        chk("rst_a_busy", 64'(a_busy), 64'(0));
        chk("rst_a_done", 64'(a_done), 64'(0));
        chk("rst_b_in_ready", 64'(b_in_ready), 64'(0));
        chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) pix_a[i] = mk2(i, -i);
        exp_a[0] = mk2(2, -3);  exp_a[1] = mk2(4, -5);
        exp_a[2] = mk2(10, -11); exp_a[3] = mk2(12, -13);
        frame_a(1'b0, -1, 16, 1'b1);

        exp_a[0] = mk2(5, 0);   exp_a[1] = mk2(7, -2);
        exp_a[2] = mk2(13, -8); exp_a[3] = mk2(15, -10);
        frame_a(1'b1, -1, 16, 1'b1);

        for (int i = 0; i < 16; i++) pix_a[i] = '0;
        pix_a[0] = mk2(-1, 1); pix_a[1] = mk2(-2, 2);
        pix_a[4] = mk2(-3, 3); pix_a[5] = mk2(-4, 4);
        exp_a[0] = mk2(-3, 2); exp_a[1] = '0; exp_a[2] = '0; exp_a[3] = '0;
        frame_a(1'b0, -1, 16, 1'b1);
        exp_a[0] = mk2(-1, 4);
        frame_a(1'b1, -1, 16, 1'b1);

        for (int i = 0; i < 16; i++) pix_a[i] = mk2(i, -i);
        exp_a[0] = mk2(2, -3);  exp_a[1] = mk2(4, -5);
        exp_a[2] = mk2(10, -11); exp_a[3] = mk2(12, -13);
        frame_a(1'b0, -1, 7, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        chk("midrst_a_in_ready", 64'(a_in_ready), 64'(0));
        chk("midrst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("midrst_a_out_data", a_out_data, 64'(0));
        chk("midrst_a_busy", 64'(a_busy), 64'(0));
        chk("midrst_a_done", 64'(a_done), 64'(0));

        for (int i = 0; i < 16; i++) pix_a[i] = mk2(100 + i, -(100 + i));
        exp_a[0] = mk2(102, -103); exp_a[1] = mk2(104, -105);
        exp_a[2] = mk2(110, -111); exp_a[3] = mk2(112, -113);
        frame_a(1'b0, 8, 16, 1'b1);

        b_rand = 1'b1;
        frame_b(1'b0);
        frame_b(1'b1);
        b_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
